// File: rtl/sce_ram_pkg.sv
// Shared definitions for the SCE crypto RAM models: zeroize sequencer states
// and the default geometry of each RAM flavour.
package sce_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } zero_state_t;

   localparam int AES_DW  = 36;
   localparam int AES_AW  = 8;
   localparam int PKE_DW  = 72;
   localparam int PKE_AW  = 9;
   localparam int HASH_DW = 36;
   localparam int HASH_AW = 10;
   localparam int ALU_DW  = 36;
   localparam int ALU_AW  = 10;
   localparam int SCE_DW  = 36;
   localparam int SCE_AW  = 12;
   localparam int DEFAULT_WS = 1;

   function automatic int num_lanes(input int dw, input int ws);
      return dw / ws;
   endfunction

endpackage

// File: rtl/sce_ram_zero_seq.sv
// Zeroize sequencer: walks the whole array once, writing a latched fill
// pattern, and owns the RAM write port for the duration of the pass.
module sce_ram_zero_seq
   import sce_ram_pkg::*;
#(
   parameter int DW    = 36,
   parameter int AW    = 10,
   parameter int DEPTH = 2**AW
)
(
   input  logic          clk,
   input  logic          resetn,
   input  logic          zero_req,
   input  logic [DW-1:0] zero_fill,
   output logic          we,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   zero_state_t   state_reg;
   logic [AW-1:0] cnt_reg;
   logic [DW-1:0] fill_reg;
   logic          done_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         fill_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (zero_req) begin
                  state_reg <= CLEAR;
                  cnt_reg   <= '0;
                  fill_reg  <= zero_fill;
               end
            end
            CLEAR: begin
               // The counter parks on the last address rather than wrapping.
               if (cnt_reg == LAST_ADDR) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign we   = (state_reg == CLEAR);
   assign addr = cnt_reg;
   assign data = fill_reg;
   assign busy = (state_reg != IDLE);
   assign done = done_reg;

endmodule

// File: rtl/sce_ram_sp_zeroize.sv
// Single-port synchronous SRAM model with lane write mask, retention gate,
// out-of-range detection and a built-in zeroize sequencer.
module sce_ram_sp_zeroize
   import sce_ram_pkg::*;
#(
   parameter int DW    = 36,
   parameter int AW    = 10,
   parameter int DEPTH = 2**AW,
   parameter int WS    = 1
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             cen,
   input  logic             gwen,
   input  logic [DW/WS-1:0] wen,
   input  logic [AW-1:0]    a,
   input  logic [DW-1:0]    d,
   output logic [DW-1:0]    q,
   input  logic             ret1n,
   output logic             rdy,
   input  logic             zero_req,
   input  logic [DW-1:0]    zero_fill,
   output logic             zero_busy,
   output logic             zero_done,
   output logic             oor_err
);

   localparam int NL = DW / WS;
   localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];

   logic          seq_we;
   logic [AW-1:0] seq_addr;
   logic [DW-1:0] seq_data;

   logic          host_acc;
   logic          in_range;
   logic [NL-1:0] host_lane_we;
   logic [NL-1:0] lane_we;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] q_reg;
   logic          oor_reg;

   sce_ram_zero_seq #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_zero_seq (
      .clk       (clk),
      .resetn    (resetn),
      .zero_req  (zero_req),
      .zero_fill (zero_fill),
      .we        (seq_we),
      .addr      (seq_addr),
      .data      (seq_data),
      .busy      (zero_busy),
      .done      (zero_done)
   );

   assign rdy      = ~zero_busy;
   assign host_acc = ~cen & ret1n & rdy;
   assign in_range = ({1'b0, a} < DEPTH_EXT);

   generate
      for (genvar gi = 0; gi < NL; gi++) begin : g_lane_we
         assign host_lane_we[gi] = host_acc & in_range & ~gwen & ~wen[gi];
      end
   endgenerate

   // Sequencer takes the write port outright while it is clearing.
   always_comb begin
      lane_we = host_lane_we;
      wr_addr = a;
      wr_data = d;
      if (seq_we) begin
         lane_we = '1;
         wr_addr = seq_addr;
         wr_data = seq_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (lane_we[i]) begin
            mem[wr_addr][WS*i +: WS] <= wr_data[WS*i +: WS];
         end
      end
   end

   // Reads sample the array before this edge's write lands: old data returned.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_reg   <= '0;
         oor_reg <= 1'b0;
      end else begin
         oor_reg <= host_acc & ~in_range;
         if (host_acc) begin
            q_reg <= in_range ? mem[a] : '0;
         end
      end
   end

   assign q       = q_reg;
   assign oor_err = oor_reg;

endmodule

// File: tb/tb_sce_ram_sp_zeroize.sv
// Self-checking bench for sce_ram_sp_zeroize (DW=36, WS=9, AW=4, DEPTH=12)
// using a word model and a queue of expected read data.
module tb_sce_ram_sp_zeroize;

   localparam int DW    = 36;
   localparam int AW    = 4;
   localparam int DEPTH = 12;
   localparam int WS    = 9;
   localparam int NL    = DW / WS;

   logic          clk;
   logic          resetn;
   logic          cen;
   logic          gwen;
   logic [NL-1:0] wen;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [DW-1:0] q;
   logic          ret1n;
   logic          rdy;
   logic          zero_req;
   logic [DW-1:0] zero_fill;
   logic          zero_busy;
   logic          zero_done;
   logic          oor_err;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] last_q;
   logic [DW-1:0] exp_q [$];

   sce_ram_sp_zeroize #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH),
      .WS    (WS)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cen       (cen),
      .gwen      (gwen),
      .wen       (wen),
      .a         (a),
      .d         (d),
      .q         (q),
      .ret1n     (ret1n),
      .rdy       (rdy),
      .zero_req  (zero_req),
      .zero_fill (zero_fill),
      .zero_busy (zero_busy),
      .zero_done (zero_done),
      .oor_err   (oor_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One host cycle driven from a negedge; result checked at the next negedge.
   task automatic access(input logic c, input logic gw, input logic [NL-1:0] w,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input string tag);
      logic          acc;
      logic          exp_oor;
      logic [DW-1:0] want;
      cen = c; gwen = gw; wen = w; a = addr; d = data;
      acc     = !c && ret1n;
      exp_oor = acc && (int'(addr) >= DEPTH);
      if (acc) last_q = (int'(addr) < DEPTH) ? model[addr] : '0;
      exp_q.push_back(last_q);
      if (acc && int'(addr) < DEPTH && !gw) begin
         for (int i = 0; i < NL; i++)
            if (!w[i]) model[addr][WS*i +: WS] = data[WS*i +: WS];
      end
      @(posedge clk);
      #1;
      cen = 1'b1; gwen = 1'b1; wen = '1;
      @(negedge clk);
      want = exp_q.pop_front();
      $display("txn %s cen=%b gwen=%b wen=%b a=%0d d=%h q=%h oor=%b", tag, c, gw, w, addr, data, q, oor_err);
      checks++;
      if (q !== want) begin
         errors++;
         $display("FAIL %s_q actual=%h expected=%h", tag, q, want);
      end
      checks++;
      if (oor_err !== exp_oor) begin
         errors++;
         $display("FAIL %s_oor actual=%b expected=%b", tag, oor_err, exp_oor);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (q !== '0 || rdy !== 1'b1 || zero_busy !== 1'b0 || zero_done !== 1'b0 || oor_err !== 1'b0) begin
         errors++;
         $display("FAIL %s actual q=%h rdy=%b busy=%b done=%b oor=%b expected q=0 rdy=1 busy=0 done=0 oor=0",
                  tag, q, rdy, zero_busy, zero_done, oor_err);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      check_idle_outputs("reset_hold");
      resetn = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_release");
      last_q = '0;
   endtask

   task automatic test_lane_mask();
      access(1'b0, 1'b0, 4'b0000, 4'd5, 36'hF_FFFF_FFFF, "mask_wr_ones");
      access(1'b0, 1'b0, 4'b1010, 4'd5, 36'h0_0000_0000, "mask_wr_zero");
      access(1'b0, 1'b1, 4'b1111, 4'd5, 36'h0, "mask_rd");
      checks++;
      if (q !== 36'hFF803FE00) begin
         errors++;
         $display("FAIL mask_const actual=%h expected=%h", q, 36'hFF803FE00);
      end
   endtask

   task automatic test_read_during_write();
      access(1'b0, 1'b0, 4'b0000, 4'd7, 36'h123, "rdw_wr");
      access(1'b0, 1'b0, 4'b0000, 4'd7, 36'h456, "rdw_rw");
      access(1'b0, 1'b1, 4'b1111, 4'd7, 36'h0, "rdw_rd");
      access(1'b1, 1'b1, 4'b1111, 4'd2, 36'h0, "rdw_hold");
   endtask

   task automatic test_out_of_range();
      access(1'b0, 1'b0, 4'b0000, 4'd11, 36'hABC, "oor_wr11");
      access(1'b0, 1'b0, 4'b0000, 4'd1, 36'h111, "oor_wr1");
      access(1'b0, 1'b0, 4'b0000, 4'd13, 36'h555, "oor_wr13");
      @(negedge clk);
      checks++;
      if (oor_err !== 1'b0) begin
         errors++;
         $display("FAIL oor_pulse_width actual=%b expected=0", oor_err);
      end
      access(1'b0, 1'b1, 4'b1111, 4'd11, 36'h0, "oor_rd11");
      access(1'b0, 1'b1, 4'b1111, 4'd1, 36'h0, "oor_rd1");
   endtask

   task automatic test_retention();
      access(1'b0, 1'b0, 4'b0000, 4'd2, 36'h111, "ret_wr");
      access(1'b0, 1'b1, 4'b1111, 4'd2, 36'h0, "ret_rd");
      ret1n = 1'b0;
      access(1'b0, 1'b0, 4'b0000, 4'd2, 36'h222, "ret_blocked");
      ret1n = 1'b1;
      access(1'b0, 1'b1, 4'b1111, 4'd2, 36'h0, "ret_rd2");
      access(1'b0, 1'b0, 4'b0000, 4'd2, 36'h333, "ret_wr2");
      access(1'b0, 1'b1, 4'b1111, 4'd2, 36'h0, "ret_rd3");
   endtask

   task automatic test_zeroize();
      logic [DW-1:0] fill;
      int busy_cycles;
      int done_cycle;
      int done_count;
      fill = 36'hA5A5A5A5A;
      busy_cycles = 0; done_cycle = -1; done_count = 0;
      zero_fill = fill;
      zero_req  = 1'b1;
      @(negedge clk);
      zero_req = 1'b0;
      cen = 1'b0; gwen = 1'b0; wen = '0; a = 4'd3; d = 36'h0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (zero_busy !== 1'b1) break;
         busy_cycles++;
         checks++;
         if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL zero_rdy cycle=%0d actual=%b expected=0", cyc, rdy);
         end
         if (zero_done === 1'b1) begin
            done_count++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         @(negedge clk);
      end
      cen = 1'b1; gwen = 1'b1; wen = '1;
      $display("txn zeroize fill=%h busy_cycles=%0d done_cycle=%0d", fill, busy_cycles, done_cycle);
      checks++;
      if (busy_cycles != 13) begin
         errors++;
         $display("FAIL zero_busy_len actual=%0d expected=13", busy_cycles);
      end
      checks++;
      if (done_cycle != 13 || done_count != 1) begin
         errors++;
         $display("FAIL zero_done_pulse actual cycle=%0d count=%0d expected cycle=13 count=1", done_cycle, done_count);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = fill;
      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 4'b1111, AW'(i), 36'h0, "zero_rd");
   endtask

   task automatic test_reset_during_clear();
      logic [DW-1:0] fill;
      fill = 36'h5A5A5A5A5;
      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b0, 4'b0000, AW'(i), 36'h1, "abort_pre");
      zero_fill = fill;
      zero_req  = 1'b1;
      @(negedge clk);
      zero_req = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_idle_outputs("abort_async");
      last_q = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (zero_done !== 1'b0 || zero_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done actual done=%b busy=%b expected done=0 busy=0", zero_done, zero_busy);
         end
      end
      for (int i = 0; i < 5; i++) model[i] = fill;
      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 4'b1111, AW'(i), 36'h0, "abort_rd");
   endtask

   initial begin
      resetn = 1'b0; cen = 1'b1; gwen = 1'b1; wen = '1; a = '0; d = '0;
      ret1n = 1'b1; zero_req = 1'b0; zero_fill = '0;
      last_q = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      test_reset();
      test_lane_mask();
      test_read_during_write();
      test_out_of_range();
      test_retention();
      test_zeroize();
      test_reset_during_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
